// File: rtl/router_pkg.sv
// Shared definitions for the 1x3 packet router: byte width and header address encodings.
package router_pkg;

  localparam int DATA_W = 8;
  localparam logic [1:0] ADDR_INVALID = 2'b11;

  function automatic logic addr_valid(input logic [1:0] addr);
    return addr != ADDR_INVALID;
  endfunction

endpackage

// File: rtl/router_reg.sv
// Router datapath register stage: header capture, byte forwarding to the FIFO, full-FIFO byte
// parking and running XOR parity check against the trailing parity byte.
module router_reg #(
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              pkt_valid,
  input  logic [DATA_W-1:0] data_in,
  input  logic              fifo_full,
  input  logic              detect_add,
  input  logic              ld_state,
  input  logic              laf_state,
  input  logic              full_state,
  input  logic              lfd_state,
  input  logic              rst_int_reg,
  output logic              err,
  output logic              parity_done,
  output logic              low_packet_valid,
  output logic [DATA_W-1:0] dout
);
  import router_pkg::*;

  logic [DATA_W-1:0] hdr_byte_q,   hdr_byte_d;
  logic [DATA_W-1:0] full_byte_q,  full_byte_d;
  logic [DATA_W-1:0] int_parity_q, int_parity_d;
  logic [DATA_W-1:0] pkt_parity_q, pkt_parity_d;
  logic [DATA_W-1:0] dout_q,       dout_d;
  logic              lpv_q,        lpv_d;
  logic              pdone_q,      pdone_d;
  logic              err_q,        err_d;

  always_comb begin
    hdr_byte_d   = hdr_byte_q;
    full_byte_d  = full_byte_q;
    int_parity_d = int_parity_q;
    pkt_parity_d = pkt_parity_q;
    dout_d       = dout_q;
    lpv_d        = lpv_q;
    pdone_d      = pdone_q;
    err_d        = err_q;

    // An invalid address leaves the previous header in place.
    if (detect_add && pkt_valid && addr_valid(data_in[1:0]))
      hdr_byte_d = data_in;

    if (lfd_state)
      dout_d = hdr_byte_q;
    else if (ld_state && !fifo_full)
      dout_d = data_in;
    else if (laf_state)
      dout_d = full_byte_q;

    if (ld_state && fifo_full)
      full_byte_d = data_in;

    // The parked byte was already folded in when first seen, so FULL/LAF states skip it.
    if (detect_add)
      int_parity_d = '0;
    else if (lfd_state && pkt_valid)
      int_parity_d = int_parity_q ^ hdr_byte_q;
    else if (ld_state && pkt_valid && !full_state)
      int_parity_d = int_parity_q ^ data_in;

    if (detect_add)
      pkt_parity_d = '0;
    else if (ld_state && !pkt_valid && !fifo_full)
      pkt_parity_d = data_in;

    if (rst_int_reg)
      lpv_d = 1'b0;
    else if (ld_state && !pkt_valid)
      lpv_d = 1'b1;

    if (detect_add)
      pdone_d = 1'b0;
    else if ((ld_state && !fifo_full && !pkt_valid) || (laf_state && lpv_q && !pdone_q))
      pdone_d = 1'b1;

    if (detect_add)
      err_d = 1'b0;
    else if (pdone_q)
      err_d = (int_parity_q != pkt_parity_q);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      hdr_byte_q   <= '0;
      full_byte_q  <= '0;
      int_parity_q <= '0;
      pkt_parity_q <= '0;
      dout_q       <= '0;
      lpv_q        <= 1'b0;
      pdone_q      <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      hdr_byte_q   <= hdr_byte_d;
      full_byte_q  <= full_byte_d;
      int_parity_q <= int_parity_d;
      pkt_parity_q <= pkt_parity_d;
      dout_q       <= dout_d;
      lpv_q        <= lpv_d;
      pdone_q      <= pdone_d;
      err_q        <= err_d;
    end
  end

  assign dout             = dout_q;
  assign low_packet_valid = lpv_q;
  assign parity_done      = pdone_q;
  assign err              = err_q;

endmodule

// File: tb/tb_router_reg.sv
// Directed bench for router_reg: good/bad packets, FIFO-full parking, invalid address, resets.
module tb_router_reg;

  logic       clock = 1'b0;
  logic       resetn;
  logic       pkt_valid, fifo_full, detect_add, ld_state, laf_state, full_state, lfd_state;
  logic       rst_int_reg;
  logic [7:0] data_in;
  logic       err, parity_done, low_packet_valid;
  logic [7:0] dout;

  int n_tests = 0;
  int n_fail  = 0;

  router_reg #(.DATA_W(8)) dut (
    .clock           (clock),
    .resetn          (resetn),
    .pkt_valid       (pkt_valid),
    .data_in         (data_in),
    .fifo_full       (fifo_full),
    .detect_add      (detect_add),
    .ld_state        (ld_state),
    .laf_state       (laf_state),
    .full_state      (full_state),
    .lfd_state       (lfd_state),
    .rst_int_reg     (rst_int_reg),
    .err             (err),
    .parity_done     (parity_done),
    .low_packet_valid(low_packet_valid),
    .dout            (dout)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of FSM strobes and data, then sample 1 time unit after the edge.
  task automatic cyc(input logic da, input logic lfd, input logic ld, input logic laf,
                     input logic fs, input logic ff, input logic pv, input logic ri,
                     input logic [7:0] d);
    detect_add = da; lfd_state = lfd; ld_state = ld; laf_state = laf;
    full_state = fs; fifo_full = ff; pkt_valid = pv; rst_int_reg = ri; data_in = d;
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 8'h00);
  endtask

  // Header, payload bytes 1..n, parity byte; optional FIFO-full stall on payload byte full_at.
  task automatic send_pkt(input string tag, input logic [7:0] hdr, input int n,
                          input logic [7:0] parity, input logic exp_err, input int full_at);
    cyc(1, 0, 0, 0, 0, 0, 1, 0, hdr);
    check({tag, "_err_clr"}, {7'd0, err}, 8'h00);
    check({tag, "_pdone_clr"}, {7'd0, parity_done}, 8'h00);
    cyc(0, 1, 0, 0, 0, 0, 1, 0, 8'h01);
    check({tag, "_dout_hdr"}, dout, hdr);
    for (int k = 1; k <= n; k++) begin
      if (k == full_at) begin
        cyc(0, 0, 1, 0, 0, 1, 1, 0, 8'(k));
        check({tag, "_dout_hold"}, dout, 8'(k - 1));
        cyc(0, 0, 0, 0, 1, 1, 1, 0, 8'(k + 1));
        check({tag, "_dout_full"}, dout, 8'(k - 1));
        cyc(0, 0, 0, 1, 0, 0, 1, 0, 8'(k + 1));
        check({tag, "_dout_laf"}, dout, 8'(k));
      end else begin
        cyc(0, 0, 1, 0, 0, 0, 1, 0, 8'(k));
        check({tag, "_dout_pl"}, dout, 8'(k));
      end
    end
    cyc(0, 0, 1, 0, 0, 0, 0, 0, parity);
    check({tag, "_dout_par"}, dout, parity);
    check({tag, "_pdone"}, {7'd0, parity_done}, 8'h01);
    check({tag, "_lpv"}, {7'd0, low_packet_valid}, 8'h01);
    idle();
    check({tag, "_err"}, {7'd0, err}, {7'd0, exp_err});
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 8'h00);
    check({tag, "_lpv_clr"}, {7'd0, low_packet_valid}, 8'h00);
    check({tag, "_err_hold"}, {7'd0, err}, {7'd0, exp_err});
  endtask

  initial begin
    resetn = 1'b0;
    detect_add = 0; lfd_state = 0; ld_state = 0; laf_state = 0;
    full_state = 0; fifo_full = 0; pkt_valid = 0; rst_int_reg = 0; data_in = 8'h00;
    #3;
    check("rst_dout", dout, 8'h00);
    check("rst_err", {7'd0, err}, 8'h00);
    check("rst_pdone", {7'd0, parity_done}, 8'h00);
    check("rst_lpv", {7'd0, low_packet_valid}, 8'h00);
    #10 resetn = 1'b1;

    // 0x16 ^ 01 ^ 02 ^ 03 ^ 04 ^ 05 = 0x17
    send_pkt("good", 8'h16, 5, 8'h17, 1'b0, 0);
    send_pkt("bad", 8'h16, 5, 8'h2E, 1'b1, 0);
    send_pkt("full", 8'h16, 5, 8'h17, 1'b0, 3);
    send_pkt("bad2", 8'h16, 5, 8'h2E, 1'b1, 0);

    // Asynchronous reset between clock edges with err/parity_done/dout all non-zero.
    #2 resetn = 1'b0;
    #1;
    check("mid_rst_dout", dout, 8'h00);
    check("mid_rst_err", {7'd0, err}, 8'h00);
    check("mid_rst_pdone", {7'd0, parity_done}, 8'h00);
    check("mid_rst_lpv", {7'd0, low_packet_valid}, 8'h00);
    #1 resetn = 1'b1;

    // Parity byte arrives while FIFO is full: parity_done waits for LOAD_AFTER_FULL.
    cyc(1, 0, 0, 0, 0, 0, 1, 0, 8'h09);
    cyc(0, 1, 0, 0, 0, 0, 1, 0, 8'h01);
    check("fp_dout_hdr", dout, 8'h09);
    cyc(0, 0, 1, 0, 0, 0, 1, 0, 8'h01);
    cyc(0, 0, 1, 0, 0, 0, 1, 0, 8'h02);
    cyc(0, 0, 1, 0, 0, 1, 0, 0, 8'h0A);
    check("fp_dout_hold", dout, 8'h02);
    check("fp_pdone_wait", {7'd0, parity_done}, 8'h00);
    check("fp_lpv", {7'd0, low_packet_valid}, 8'h01);
    cyc(0, 0, 0, 0, 1, 1, 0, 0, 8'h0A);
    check("fp_pdone_full", {7'd0, parity_done}, 8'h00);
    cyc(0, 0, 0, 1, 0, 0, 0, 0, 8'h0A);
    check("fp_dout_laf", dout, 8'h0A);
    check("fp_pdone_laf", {7'd0, parity_done}, 8'h01);

    // Address 3 header is ignored; previous header 0x09 is replayed on LOAD_FIRST_DATA.
    cyc(1, 0, 0, 0, 0, 0, 1, 0, 8'h17);
    cyc(0, 1, 0, 0, 0, 0, 1, 0, 8'h01);
    check("inv_hdr_kept", dout, 8'h09);
    check("inv_lpv_held", {7'd0, low_packet_valid}, 8'h01);
    cyc(0, 0, 0, 0, 0, 0, 1, 1, 8'h01);
    check("inv_lpv_clr", {7'd0, low_packet_valid}, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
